// File: rtl/bcd_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_timer_if
// Connection bundle between the keypad decoder / game logic (master) and the
// BCD preset timer (slave).
//
// Handshake: key_valid is a one-cycle strobe that qualifies key_code. There is
// no back-pressure. The timer takes the key in the cycle key_valid is high, and
// it drops any code it has no use for in its current state.
//
// Signals (direction as seen from the timer):
//   enable     in   0 forces the timer back to an empty SET state
//   key_valid  in   key strobe
//   key_code   in   0-9 digit, A start, B pause/resume, C clear
//   dir_up     in   count direction, sampled only on start
//   value      out  current BCD value, digit 0 in [3:0]
//   seg        out  7-segment pattern per digit (gfedcba), digit 0 in [6:0]
//   running    out  timer is counting
//   paused     out  timer is paused
//   done       out  one-cycle pulse on reaching terminal count
//   expired    out  held while the terminal count is displayed
//   state_dbg  out  raw FSM state for checkers
// ---------------------------------------------------------------------------
interface bcd_timer_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic                  key_valid;
   logic [3:0]            key_code;
   logic                  dir_up;
   logic [4*DIGITS-1:0]   value;
   logic [7*DIGITS-1:0]   seg;
   logic                  running;
   logic                  paused;
   logic                  done;
   logic                  expired;
   logic [1:0]            state_dbg;

   modport master (
      output enable, key_valid, key_code, dir_up,
      input  value, seg, running, paused, done, expired, state_dbg
   );

   modport slave (
      input  enable, key_valid, key_code, dir_up,
      output value, seg, running, paused, done, expired, state_dbg
   );
endinterface

// File: rtl/bcd_timer.sv
// ---------------------------------------------------------------------------
// bcd_timer
// N-digit BCD preset timer. You enter digits from the keypad. The timer then
// counts down to zero, or up from zero to the preset, at one step every
// TICK_DIV clocks. When it reaches terminal count it pulses done and holds
// expired.
//
// Ports:
//   clk_in  system clock, rising edge
//   rst     asynchronous reset, active low
//   bus     bcd_timer_if.slave: keypad inputs, display and status outputs
//
// Parameters:
//   DIGITS          number of BCD digits (1..8)
//   TICK_DIV        clocks per count step (>=1)
//   SEG_ACTIVE_LOW  1: lit segment driven as 0
// ---------------------------------------------------------------------------
module bcd_timer #(
   parameter int DIGITS         = 4,
   parameter int TICK_DIV       = 50000000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic         clk_in,
   input  logic         rst,
   bcd_timer_if.slave   bus
);

   localparam int VW = 4 * DIGITS;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   localparam logic [3:0] KEY_START = 4'hA;
   localparam logic [3:0] KEY_PAUSE = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;

   typedef enum logic [1:0] {
      ST_SET   = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [VW-1:0]   value_q, value_d;
   logic [VW-1:0]   preset_q, preset_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic            mode_up_q, mode_up_d;
   logic            running_q, running_d;
   logic            paused_q, paused_d;
   logic            done_q, done_d;
   logic            expired_q, expired_d;

   logic            key_digit, key_start, key_pause, key_clear, key_any;
   logic            tick_step, terminal;
   logic [VW-1:0]   shifted, stepped;
   logic [7*DIGITS-1:0] seg_d;

   // BCD increment: ripple a carry through the digits, each rolling 9 -> 0.
   function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // BCD decrement: ripple a borrow through the digits, each rolling 0 -> 9.
   function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Active-high gfedcba patterns. Nibbles that are not BCD stay blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return SEG_ACTIVE_LOW ? ~p : p;
   endfunction

   assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
   assign key_start = bus.key_valid && (bus.key_code == KEY_START);
   assign key_pause = bus.key_valid && (bus.key_code == KEY_PAUSE);
   assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
   assign key_any   = bus.key_valid && (bus.key_code <= KEY_CLEAR);

   // The new digit enters at digit 0 and the top digit falls off the end.
   assign shifted   = (value_q << 4) | VW'(bus.key_code);
   assign stepped   = mode_up_q ? bcd_inc(value_q) : bcd_dec(value_q);
   assign tick_step = (tick_q == TICK_LAST);
   assign terminal  = mode_up_q ? (stepped == preset_q) : (stepped == '0);

   // State register
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_SET;
         value_q   <= '0;
         preset_q  <= '0;
         tick_q    <= '0;
         mode_up_q <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         done_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         preset_q  <= preset_d;
         tick_q    <= tick_d;
         mode_up_q <= mode_up_d;
         running_q <= running_d;
         paused_q  <= paused_d;
         done_q    <= done_d;
         expired_q <= expired_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      preset_d  = preset_q;
      tick_d    = tick_q;
      mode_up_d = mode_up_q;
      if (!bus.enable) begin
         state_d  = ST_SET;
         value_d  = '0;
         preset_d = '0;
         tick_d   = '0;
      end else begin
         case (state_q)
            ST_SET: begin
               if (key_digit) begin
                  value_d  = shifted;
                  preset_d = shifted;
               end else if (key_start && (preset_q != '0)) begin
                  // Load the preset again. After DONE the display shows 0
                  // while the preset is kept, and start must re-run it.
                  mode_up_d = bus.dir_up;
                  value_d   = bus.dir_up ? '0 : preset_q;
                  tick_d    = '0;
                  state_d   = ST_RUN;
               end else if (key_clear) begin
                  value_d  = '0;
                  preset_d = '0;
               end
            end
            ST_RUN: begin
               if (key_clear) begin
                  state_d  = ST_SET;
                  value_d  = '0;
                  preset_d = '0;
                  tick_d   = '0;
               end else begin
                  // The cycle that takes the pause key still counts, so a
                  // step that falls on it still happens.
                  if (tick_step) begin
                     tick_d  = '0;
                     value_d = stepped;
                  end else begin
                     tick_d = tick_q + TW'(1);
                  end
                  if (tick_step && terminal) begin
                     state_d = ST_DONE;
                  end else if (key_pause) begin
                     state_d = ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (key_pause) begin
                  state_d = ST_RUN;
               end else if (key_clear) begin
                  state_d  = ST_SET;
                  value_d  = '0;
                  preset_d = '0;
                  tick_d   = '0;
               end
            end
            ST_DONE: begin
               if (key_any) begin
                  state_d = ST_SET;
                  value_d = '0;
               end
            end
            default: state_d = ST_SET;
         endcase
      end
   end

   // Output decode. Flags are computed from the next state so they register
   // in the same edge as the state itself.
   always_comb begin
      running_d = (state_d == ST_RUN);
      paused_d  = (state_d == ST_PAUSE);
      expired_d = (state_d == ST_DONE);
      done_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
      seg_d     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         seg_d[7*i +: 7] = seg_decode(value_q[4*i +: 4]);
      end
   end

   assign bus.value     = value_q;
   assign bus.seg       = seg_d;
   assign bus.running   = running_q;
   assign bus.paused    = paused_q;
   assign bus.done      = done_q;
   assign bus.expired   = expired_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bcd_timer.sv
module tb_bcd_timer;

   localparam int D    = 4;
   localparam int TD   = 4;
   localparam int W    = 11 * D + 4;
   localparam int MAXV = 10 ** D;
   localparam logic [6:0] SEG_HI [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic clk_in = 1'b0;
   logic rst    = 1'b0;

   bcd_timer_if #(.DIGITS(D)) bus ();

   bcd_timer #(.DIGITS(D), .TICK_DIV(TD), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_in = ~clk_in;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Model phases: 0 entering, 1 counting, 2 paused, 3 expired.
   typedef struct {
      int st;
      int val;
      int pre;
      int phase;
      bit up;
      bit done;
   } ms_t;

   ms_t ms;
   logic [W-1:0] exp_q[$];

   function automatic ms_t ms_reset();
      ms_t n;
      n.st = 0; n.val = 0; n.pre = 0; n.phase = 0; n.up = 1'b0; n.done = 1'b0;
      return n;
   endfunction

   function automatic ms_t model_next(ms_t s, bit en, bit kv, logic [3:0] kc, bit du);
      ms_t n;
      bit  k;
      int  c;
      n      = s;
      n.done = 1'b0;
      c      = int'(kc);
      k      = kv && (c <= 12);
      if (!en) begin
         n.st = 0; n.val = 0; n.pre = 0; n.phase = 0;
         return n;
      end
      case (s.st)
         0: if (k) begin
            if (c < 10) begin
               n.val = (s.val * 10 + c) % MAXV;
               n.pre = n.val;
            end else if (c == 10 && s.pre != 0) begin
               n.up = du; n.val = du ? 0 : s.pre; n.phase = 0; n.st = 1;
            end else if (c == 12) begin
               n.val = 0; n.pre = 0;
            end
         end
         1: if (k && c == 12) begin
            n.st = 0; n.val = 0; n.pre = 0; n.phase = 0;
         end else begin
            n.phase = s.phase + 1;
            if (n.phase == TD) begin
               n.phase = 0;
               n.val   = s.up ? s.val + 1 : s.val - 1;
               if (n.val == (s.up ? s.pre : 0)) begin
                  n.st = 3; n.done = 1'b1;
               end
            end
            if (n.st == 1 && k && c == 11) n.st = 2;
         end
         2: if (k && c == 11) n.st = 1;
            else if (k && c == 12) begin
               n.st = 0; n.val = 0; n.pre = 0;
            end
         default: if (k) begin
            n.st = 0; n.val = 0;
         end
      endcase
      return n;
   endfunction

   function automatic logic [W-1:0] expect_of(ms_t s);
      logic [4*D-1:0] b;
      logic [7*D-1:0] sg;
      int dg;
      for (int i = 0; i < D; i++) begin
         dg            = (s.val / (10 ** i)) % 10;
         b[4*i +: 4]   = 4'(dg);
         sg[7*i +: 7]  = ~SEG_HI[dg];
      end
      return {b, sg, s.st == 1, s.st == 2, s.done, s.st == 3};
   endfunction

   always @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         ms <= ms_reset();
      end else begin
         ms <= model_next(ms, bus.enable, bus.key_valid, bus.key_code, bus.dir_up);
         exp_q.push_back(expect_of(model_next(ms, bus.enable, bus.key_valid,
                                              bus.key_code, bus.dir_up)));
      end
   end

   // Scoreboard: every cycle the DUT outputs are compared with the model.
   always @(negedge clk_in) begin
      logic [W-1:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("cycle_model",
               {bus.value, bus.seg, bus.running, bus.paused, bus.done, bus.expired}, e);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic press(input logic [3:0] c);
      @(negedge clk_in);
      bus.key_code  = c;
      bus.key_valid = 1'b1;
      @(negedge clk_in);
      bus.key_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max, output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < max) begin
         @(negedge clk_in);
         n++;
      end
      check(name, bus.done, 1);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [3:0]  key;
      bit          du;
      logic [15:0] exp_val;
      bit          exp_run;
   } vec_t;

   vec_t vt [13];

   initial begin
      int n;
      bit saw, held;
      logic [15:0] prev;
      logic [27:0] zero_seg;

      vt[0]  = '{4'h5, 1'b0, 16'h0005, 1'b0};
      vt[1]  = '{4'h6, 1'b0, 16'h0056, 1'b0};
      vt[2]  = '{4'h7, 1'b0, 16'h0567, 1'b0};
      vt[3]  = '{4'h8, 1'b0, 16'h5678, 1'b0};
      vt[4]  = '{4'h9, 1'b0, 16'h6789, 1'b0};
      vt[5]  = '{4'hD, 1'b0, 16'h6789, 1'b0};
      vt[6]  = '{4'hB, 1'b0, 16'h6789, 1'b0};
      vt[7]  = '{4'hC, 1'b0, 16'h0000, 1'b0};
      vt[8]  = '{4'hA, 1'b0, 16'h0000, 1'b0};
      vt[9]  = '{4'h1, 1'b0, 16'h0001, 1'b0};
      vt[10] = '{4'h2, 1'b0, 16'h0012, 1'b0};
      vt[11] = '{4'h0, 1'b0, 16'h0120, 1'b0};
      vt[12] = '{4'hA, 1'b0, 16'h0120, 1'b1};

      zero_seg      = {4{7'b1000000}};
      bus.enable    = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      bus.dir_up    = 1'b0;

      // reset state
      #1;
      check("reset_value", bus.value, 0);
      check("reset_flags", {bus.running, bus.paused, bus.done, bus.expired}, 0);
      check("reset_seg", bus.seg, zero_seg);
      tick(3);
      rst = 1'b1;

      // key entry, ignored keys, start with zero preset, start of test 1
      for (int i = 0; i < 13; i++) begin
         bus.dir_up = vt[i].du;
         press(vt[i].key);
         check($sformatf("vec%0d_value", i), bus.value, vt[i].exp_val);
         check($sformatf("vec%0d_running", i), bus.running, vt[i].exp_run);
      end

      // 0120 down: 120 steps of 4 cycles
      wait_done("t1_done", 1000, n);
      check("t1_latency", n, 480);
      check("t1_value", bus.value, 0);
      check("t1_flags_at_done", {bus.running, bus.expired}, 2'b01);
      tick(1);
      check("t1_done_one_cycle", {bus.done, bus.expired}, 2'b01);

      // borrow: 0100 -> 0099
      press(4'hC);
      press(4'h1); press(4'h0); press(4'h0);
      bus.dir_up = 1'b0;
      press(4'hA);
      tick(4);
      check("t2_borrow", bus.value, 16'h0099);
      press(4'hC);

      // carry: up to 0015
      press(4'h1); press(4'h5);
      bus.dir_up = 1'b1;
      press(4'hA);
      check("t2_up_start", bus.value, 0);
      saw  = 1'b0;
      prev = bus.value;
      n    = 0;
      while (bus.done !== 1'b1 && n < 200) begin
         @(negedge clk_in);
         n++;
         if (prev == 16'h0009 && bus.value == 16'h0010) saw = 1'b1;
         prev = bus.value;
      end
      check("t2_up_done", bus.done, 1);
      check("t2_up_value", bus.value, 16'h0015);
      check("t2_up_latency", n, 60);
      check("t2_carry_seen", saw, 1);

      // pause timing
      press(4'hC);
      bus.dir_up = 1'b0;
      press(4'h1); press(4'h0);
      press(4'hA);
      press(4'hB);
      check("t4_paused", {bus.paused, bus.running}, 2'b10);
      held = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_in);
         if (bus.value !== 16'h0010 || bus.paused !== 1'b1) held = 1'b0;
      end
      check("t4_frozen", held, 1);
      press(4'hB);
      check("t4_resumed", bus.running, 1);
      tick(1);
      check("t4_no_step_yet", bus.value, 16'h0010);
      tick(1);
      check("t4_step_after_2", bus.value, 16'h0009);
      tick(2);
      press(4'hB);
      check("t4_step_and_pause", {bus.value, bus.paused}, {16'h0008, 1'b1});

      // DONE, then digit key, then re-run of the same preset
      press(4'hC);
      press(4'h2);
      press(4'hA);
      wait_done("t5_done", 100, n);
      check("t5_latency", n, 8);
      tick(1);
      press(4'h3);
      check("t5_after_key", {bus.value, bus.expired, bus.running}, 0);
      press(4'hA);
      check("t5_rerun", {bus.value, bus.running}, {16'h0002, 1'b1});
      wait_done("t5_done2", 100, n);
      check("t5_latency2", n, 8);

      // async reset mid-run
      press(4'hC);
      press(4'h5);
      press(4'hA);
      tick(3);
      #1 rst = 1'b0;
      #1;
      check("t6_rst_value", bus.value, 0);
      check("t6_rst_flags", {bus.running, bus.paused, bus.done, bus.expired}, 0);
      tick(2);
      check("t6_rst_seg", bus.seg, zero_seg);
      rst = 1'b1;

      // enable low mid-pause, keys ignored
      press(4'h3);
      press(4'hA);
      tick(2);
      press(4'hB);
      check("t6_paused", bus.paused, 1);
      bus.enable = 1'b0;
      tick(1);
      check("t6_en_value", bus.value, 0);
      check("t6_en_flags", {bus.running, bus.paused, bus.done, bus.expired}, 0);
      press(4'h7);
      check("t6_en_key_ignored", bus.value, 0);
      bus.enable = 1'b1;
      press(4'hA);
      check("t6_start_zero_preset", {bus.value, bus.running}, 0);

      // randomized traffic against the model
      for (int it = 0; it < 400; it++) begin
         int r;
         r = $urandom_range(0, 9);
         bus.dir_up = 1'($urandom_range(0, 1));
         if (r < 5) begin
            press(4'($urandom_range(0, 15)));
         end else if (r < 8) begin
            press(4'hC);
            press(4'($urandom_range(1, 9)));
            press(4'hA);
         end else if (r == 8) begin
            @(negedge clk_in);
            bus.enable = 1'b0;
            tick($urandom_range(1, 3));
            bus.enable = 1'b1;
         end
         tick($urandom_range(0, 25));
      end
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_timer.md
Name: bcd_timer

Overview:
Parametrised N-digit BCD preset timer with keypad entry, start/pause/clear control and an up or down count mode.
- Digits are entered from a keypad decoder. The block counts at a divided tick rate.
- It drives one active-low 7-segment pattern per digit and raises a done pulse plus a held expired flag at terminal count.
- It sits between the IR/keypad decoder and the HEX display bank. Game logic consumes done/expired.

Parameters:
DIGITS, 4, number of BCD digits (1..8); value range 0 .. 10^DIGITS-1
TICK_DIV, 50000000, clk_in cycles per count step (>=1; 1 = step every cycle)
SEG_ACTIVE_LOW, 1, 1: segment outputs inverted (lit = 0); 0: lit = 1

Ports:
clk_in  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  0: synchronous clear to SET with value 0 (keys ignored); 1: normal operation
key_valid  input  1  one-cycle strobe qualifying key_code
key_code  input  4  0-9 digit, 4'hA start, 4'hB pause/resume, 4'hC clear; 4'hD-4'hF ignored
dir_up  input  1  sampled at start only: 0 count down to 0, 1 count up from 0 to preset
value  output  4*DIGITS  current BCD display value, digit 0 in bits [3:0]
seg  output  7*DIGITS  7-segment pattern per digit (gfedcba), digit 0 in bits [6:0]
running  output  1  1 in RUN
paused  output  1  1 in PAUSE
done  output  1  one-cycle pulse on entry to DONE
expired  output  1  1 while in DONE

Behaviour:
- Reset (rst=0, async): state=SET; value, preset, tick counter and mode latch all 0; running=paused=done=expired=0; seg shows all zeros.
- States: SET, RUN, PAUSE, DONE. All outputs except seg are registered. seg is combinational from value.
- SET state:
  - Digit key: value shifts left one digit; the new digit goes into digit 0; the top digit is discarded. preset<=shifted value.
  - Start key with dir_up=0: requires preset!=0. Action: mode<=down, tick counter<=0, -> RUN.
  - Start key with dir_up=1: requires preset!=0. Action: value<=0, mode<=up, tick counter<=0, -> RUN.
  - Start key with preset==0: ignored; stay in SET.
  - Clear key: value=preset=0.
  - Pause key: ignored.
- RUN state:
  - The tick counter counts 0..TICK_DIV-1 and wraps. A step occurs in the cycle the counter equals TICK_DIV-1.
  - Down step: BCD decrement with borrow across all digits.
  - Up step: BCD increment with carry.
  - Terminal condition: the post-step value equals 0 (down) or equals preset (up). On that step, go to DONE; done=1 for exactly that next cycle; expired=1 and held.
  - Pause key: -> PAUSE. The tick counter holds its count; no restart on resume.
  - Clear key: -> SET with value=preset=0.
  - Digit keys and start key: ignored.
- PAUSE state:
  - Value and tick counter frozen.
  - Pause key: -> RUN, continuing from the held tick count.
  - Clear key: -> SET with value=preset=0.
  - Other keys: ignored.
- DONE state:
  - value holds the terminal value; expired=1.
  - Any valid key (0-9, A, B, C): -> SET with value=0, preset retained. A digit key pressed here is consumed and not shifted in. Start then re-runs the same preset.
- Simultaneous events:
  - Step tick and pause key in the same cycle: the step is applied, then -> PAUSE.
  - Step tick and clear key: clear wins.
  - Terminal step and pause key: -> DONE; pause is ignored.
- enable=0 overrides all states: -> SET, value=preset=0, tick counter=0, expired=0, no done pulse. This is the same result as a clear, and it applies whenever enable is low.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse.
- Widths:
  - Tick counter is $clog2(TICK_DIV) bits, minimum 1.
  - BCD arithmetic is per digit. A digit rolls 9->0 on carry and 0->9 on borrow.
  - Down from 0 and up past the all-9s value are unreachable because of the terminal check.
- Segment decode:
  - 0-9 use the standard patterns; non-BCD nibbles are blank.
  - For SEG_ACTIVE_LOW=1: 0 = 7'b1000000, 8 = 7'b0000000.

Test Plan:
1. DIGITS=4, TICK_DIV=4; keys 1,2,0,A, dir_up=0 -> value 0x0120, running=1. value decrements every 4 cycles. After 120 steps (480 cycles): value 0x0000, done pulses for one cycle, expired=1, running=0.
2. Borrow/carry check: preset 0x0100 down -> step 1 gives 0x0099. preset 0x0015, dir_up=1 -> counts 0x0000..0x0015 (0x0009 -> 0x0010 observed), then done.
3. Keys 5,6,7,8,9 -> value 0x6789 (top digit dropped). Start with preset 0 (after clear C) -> stays SET, running=0.
4. RUN preset 0x0010: pause key 2 cycles into a tick period -> value frozen for 40 cycles. Resume -> next step after exactly 2 more cycles. Pause key and step tick in the same cycle -> value steps once, then paused=1.
5. DONE then digit key 3 -> SET, value 0, expired=0. Then A -> re-runs the previous preset.
6. rst=0 mid-RUN and enable=0 mid-PAUSE -> value 0, all flags 0, no done pulse. Keys ignored while enable=0.
